// File: rtl/led_share_arbiter.sv
// led_share_arbiter
//   Shares the four board LEDs between three requesters (0 = status,
//   1 = debug, 2 = user) and an idle pattern, normally the marquee/blink
//   engine output. Owners are chosen round-robin. Each grant is held for a
//   timed window and followed by a blank gap. All timing runs on a
//   millisecond-scale tick derived from pll_clk.
//
//   Ports
//     pll_clk      in   system clock
//     rst_sync     in   asynchronous, active-high reset
//     pll_locked   in   clock-valid qualifier; low forces IDLE with LEDs off
//     req[2:0]     in   level requests, req[i] belongs to requester i
//     req_pattern  in   requester i's pattern is bits [4i+3:4i]
//     idle_leds    in   pattern shown while nobody owns the LEDs
//     gnt[2:0]     out  one-hot grant, zero when there is no owner
//     done[2:0]    out  one-cycle pulse on bit i when requester i's hold expires
//     busy         out  high while in GRANT or GAP
//     leds[3:0]    out  registered LED drive
//
//   Handshake: a requester raises req[i] and holds it high. gnt[i] rises one
//   cycle after the arbiter samples it in IDLE. The owner keeps ownership
//   until its hold window expires (done[i] pulses) or until it drops req[i]
//   (early release, no done pulse). Requests from other requesters are
//   ignored during a grant. They are not lost as long as they stay high.
module led_share_arbiter #(
   parameter int TICK_DIV   = 200_000,
   parameter int HOLD_TICKS = 250,
   parameter int GAP_TICKS  = 2
) (
   input  logic        pll_clk,
   input  logic        rst_sync,
   input  logic        pll_locked,
   input  logic [2:0]  req,
   input  logic [11:0] req_pattern,
   input  logic [3:0]  idle_leds,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic        busy,
   output logic [3:0]  leds
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [GW-1:0] GAP_LAST  = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e          state_q,    state_d;
   logic [2:0]      gnt_q,      gnt_d;
   logic [2:0]      done_q,     done_d;
   logic            busy_q,     busy_d;
   logic [3:0]      leds_q,     leds_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [GW-1:0]   gap_cnt_q,  gap_cnt_d;
   logic [1:0]      rr_last_q,  rr_last_d;

   logic            tick;
   logic [1:0]      cand1, cand2, win;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   assign tick = (tick_cnt_q == TICK_LAST);

   // Search order starts just after the last winner, so the last winner
   // is considered only when nobody else is requesting.
   always_comb begin
      cand1 = next_idx(rr_last_q);
      cand2 = next_idx(cand1);
      if (req[cand1])      win = cand1;
      else if (req[cand2]) win = cand2;
      else                 win = rr_last_q;
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      busy_d     = busy_q;
      leds_d     = leds_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rr_last_d  = rr_last_q;

      if (!pll_locked) begin
         // Losing lock abandons any grant silently. rr_last is kept, so
         // fairness survives the outage.
         state_d    = ST_IDLE;
         gnt_d      = '0;
         busy_d     = 1'b0;
         leds_d     = '0;
         tick_cnt_d = '0;
         hold_cnt_d = '0;
         gap_cnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               leds_d = idle_leds;
               if (req != 3'b000) begin
                  state_d    = ST_GRANT;
                  gnt_d      = 3'b001 << win;
                  // The pattern is captured here. leds_q then holds it for
                  // the whole grant, whatever the source does afterwards.
                  leds_d     = req_pattern[{win, 2'b00} +: 4];
                  busy_d     = 1'b1;
                  rr_last_d  = win;
                  tick_cnt_d = '0;
                  hold_cnt_d = '0;
               end
            end

            ST_GRANT: begin
               if (tick) hold_cnt_d = hold_cnt_q + 1'b1;
               // Expiry is tested first, so a release on the final cycle
               // still produces the done pulse.
               if (tick && (hold_cnt_q == HOLD_LAST)) begin
                  state_d    = ST_GAP;
                  gnt_d      = '0;
                  done_d     = gnt_q;
                  leds_d     = '0;
                  tick_cnt_d = '0;
                  gap_cnt_d  = '0;
               end else if ((req & gnt_q) == 3'b000) begin
                  state_d    = ST_GAP;
                  gnt_d      = '0;
                  leds_d     = '0;
                  tick_cnt_d = '0;
                  gap_cnt_d  = '0;
               end
            end

            ST_GAP: begin
               if (tick) gap_cnt_d = gap_cnt_q + 1'b1;
               // A zero-length gap still spends one cycle dark.
               if ((GAP_TICKS == 0) || (tick && (gap_cnt_q == GAP_LAST))) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  leds_d  = idle_leds;
               end
            end

            default: begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               leds_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge pll_clk or posedge rst_sync) begin
      if (rst_sync) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         leds_q     <= '0;
         tick_cnt_q <= '0;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         rr_last_q  <= 2'd2;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         leds_q     <= leds_d;
         tick_cnt_q <= tick_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         rr_last_q  <= rr_last_d;
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;
   assign leds = leds_q;

endmodule
